// File: rtl/nibble_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package  : nibble_pkg                                                |
// | Purpose  : Shared types and constants for the nibble deserializer.   |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
package nibble_pkg;

  localparam int NIB_W = 4;

  typedef logic [NIB_W-1:0] nibble_t;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } nib_state_t;

endpackage
`default_nettype wire

// File: rtl/nibble_deser.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : nibble_deser                                              |
// | Purpose  : Assembles a framed serial bit stream into 4-bit nibbles,  |
// |            flags framing errors, counts delivered nibbles.           |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module nibble_deser
  import nibble_pkg::*;
#(
  parameter int MSB_FIRST = 1,
  parameter int GAP_MAX   = 8,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sdata,
  input  logic             svalid,
  input  logic             sof,
  output nibble_t          nib_out,
  output logic             nib_valid,
  output logic             frame_err,
  output logic [CNT_W-1:0] nib_cnt
);

  localparam int               GAP_W   = $clog2(GAP_MAX + 1);
  localparam logic [GAP_W-1:0] GAP_LIM = GAP_W'(GAP_MAX);

  nib_state_t       state, state_n;
  logic [1:0]       bit_idx, bit_idx_n;
  logic [GAP_W-1:0] gap, gap_n;
  nibble_t          shreg, shreg_n;
  nibble_t          nib_out_n;
  logic             nib_valid_n;
  logic             frame_err_n;
  logic [CNT_W-1:0] nib_cnt_n;
  nibble_t          assembled;

  // Drop serial bit k into its lane; for 2-bit k, 3-k is simply ~k.
  function automatic nibble_t place(input nibble_t cur, input logic [1:0] k,
                                    input logic b);
    nibble_t r;
    r = cur;
    if (MSB_FIRST != 0) r[~k] = b;
    else                r[k]  = b;
    return r;
  endfunction

  // State and output registers; reset discards any partial nibble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      bit_idx   <= 2'd0;
      gap       <= '0;
      shreg     <= '0;
      nib_out   <= '0;
      nib_valid <= 1'b0;
      frame_err <= 1'b0;
      nib_cnt   <= '0;
    end else begin
      state     <= state_n;
      bit_idx   <= bit_idx_n;
      gap       <= gap_n;
      shreg     <= shreg_n;
      nib_out   <= nib_out_n;
      nib_valid <= nib_valid_n;
      frame_err <= frame_err_n;
      nib_cnt   <= nib_cnt_n;
    end
  end

  // Next-state: framing, bit assembly, gap timeout and nibble delivery.
  always_comb begin
    state_n     = state;
    bit_idx_n   = bit_idx;
    gap_n       = gap;
    shreg_n     = shreg;
    nib_out_n   = nib_out;
    nib_valid_n = 1'b0;
    frame_err_n = 1'b0;
    nib_cnt_n   = nib_cnt;
    assembled   = '0;

    case (state)
      IDLE: begin
        if (svalid && sof) begin
          shreg_n   = place('0, 2'd0, sdata);
          bit_idx_n = 2'd1;
          gap_n     = '0;
          state_n   = SHIFT;
        end
      end

      SHIFT: begin
        if (svalid) begin
          gap_n = '0;
          if (sof && (bit_idx != 2'd0)) begin
            // Resync: the partial nibble is dropped, this bit restarts.
            frame_err_n = 1'b1;
            shreg_n     = place('0, 2'd0, sdata);
            bit_idx_n   = 2'd1;
          end else begin
            // A fresh nibble starts from a clean register.
            assembled = place((bit_idx == 2'd0) ? nibble_t'('0) : shreg,
                              bit_idx, sdata);
            shreg_n   = assembled;
            bit_idx_n = bit_idx + 2'd1;
            if (bit_idx == 2'd3) begin
              nib_out_n   = assembled;
              nib_valid_n = 1'b1;
              if (nib_cnt != {CNT_W{1'b1}}) nib_cnt_n = nib_cnt + CNT_W'(1);
            end
          end
        end else if ((gap + GAP_W'(1)) == GAP_LIM) begin
          // Stream went quiet too long: abandon, and flag if mid-nibble.
          state_n     = IDLE;
          bit_idx_n   = 2'd0;
          gap_n       = '0;
          frame_err_n = (bit_idx != 2'd0);
        end else begin
          gap_n = gap + GAP_W'(1);
        end
      end

      default: state_n = IDLE;
    endcase
  end

endmodule
`default_nettype wire
